// File: rtl/result_announcer.sv
// rtl/result_announcer.sv - snapshot four vote counts, scan for winner/tie/total, cycle the display, hold the result
module result_announcer #(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               close_poll,
    input  logic [CNT_W-1:0]   cand1_votes,
    input  logic [CNT_W-1:0]   cand2_votes,
    input  logic [CNT_W-1:0]   cand3_votes,
    input  logic [CNT_W-1:0]   cand4_votes,
    output logic               busy,
    output logic               result_valid,
    output logic [1:0]         winner,
    output logic               tie,
    output logic [CNT_W+1:0]   total_votes,
    output logic [1:0]         cand_sel,
    output logic [CNT_W-1:0]   leds
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int TOT_W  = CNT_W + 2;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  snap_q [4];
    logic [CNT_W-1:0]  snap_d [4];
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  best_q, best_d;
    logic [1:0]        winner_q, winner_d;
    logic              tie_q, tie_d;
    logic [TOT_W-1:0]  total_q, total_d;
    logic [1:0]        sel_q, sel_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  leds_q, leds_d;

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
        best_d   = best_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        total_d  = total_q;
        sel_d    = sel_q;
        hold_d   = hold_q;
        leds_d   = leds_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (close_poll) begin
                    snap_d  = '{cand1_votes, cand2_votes, cand3_votes, cand4_votes};
                    idx_d   = 2'd0;
                    sel_d   = 2'd0;
                    leds_d  = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (idx_q == 2'd0) begin
                    best_d   = snap_q[0];
                    winner_d = 2'd0;
                    tie_d    = 1'b0;
                    total_d  = TOT_W'(snap_q[0]);
                end else begin
                    // Strict greater-than keeps the lowest index on a tie.
                    if (snap_q[idx_q] > best_q) begin
                        best_d   = snap_q[idx_q];
                        winner_d = idx_q;
                        tie_d    = 1'b0;
                    end else if (snap_q[idx_q] == best_q) begin
                        tie_d = 1'b1;
                    end
                    total_d = total_q + TOT_W'(snap_q[idx_q]);
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_SHOW;
                    sel_d   = 2'd0;
                    hold_d  = '0;
                    leds_d  = snap_q[0];
                end
            end
            S_SHOW: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (sel_q == 2'd3) begin
                        state_d = S_DONE;
                        sel_d   = winner_q;
                        leds_d  = snap_q[winner_q];
                    end else begin
                        sel_d  = sel_q + 2'd1;
                        leds_d = snap_q[sel_q + 2'd1];
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            snap_q   <= '{default: '0};
            idx_q    <= '0;
            best_q   <= '0;
            winner_q <= '0;
            tie_q    <= 1'b0;
            total_q  <= '0;
            sel_q    <= '0;
            hold_q   <= '0;
            leds_q   <= '0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            best_q   <= best_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
            total_q  <= total_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
            leds_q   <= leds_d;
        end
    end

    assign busy         = (state_q == S_SCAN) || (state_q == S_SHOW);
    assign result_valid = (state_q == S_DONE);
    assign winner       = winner_q;
    assign tie          = tie_q;
    assign total_votes  = total_q;
    assign cand_sel     = sel_q;
    assign leds         = leds_q;

endmodule

// File: tb/tb_result_announcer.sv
// tb/tb_result_announcer.sv - scoreboard bench for result_announcer with a tally-level reference model
module tb_result_announcer;

    localparam int H   = 10;
    localparam int LAT = 4 + 4 * H;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       close_poll = 1'b0;
    logic [7:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
    logic       busy, result_valid, tie;
    logic [1:0] winner, cand_sel;
    logic [9:0] total_votes;
    logic [7:0] leds;

    result_announcer #(.CNT_W(8), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .close_poll(close_poll),
        .cand1_votes(c1), .cand2_votes(c2), .cand3_votes(c3), .cand4_votes(c4),
        .busy(busy), .result_valid(result_valid), .winner(winner), .tie(tie),
        .total_votes(total_votes), .cand_sel(cand_sel), .leds(leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              e0;
        logic [3:0][7:0] v;
    } tally_t;

    tally_t q[$];
    tally_t done_rec;
    bit     done_flag = 0;
    bit     active = 0;
    int     last_e0 = 0;
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_win(input logic [3:0][7:0] v);
        int mx = -1;
        int w = 0;
        for (int i = 0; i < 4; i++)
            if (int'(v[i]) > mx) begin mx = int'(v[i]); w = i; end
        return w;
    endfunction

    function automatic int m_tie(input logic [3:0][7:0] v);
        int n = 0;
        int mx = 0;
        for (int i = 0; i < 4; i++) if (int'(v[i]) > mx) mx = int'(v[i]);
        for (int i = 0; i < 4; i++) if (int'(v[i]) == mx) n++;
        return (n > 1) ? 1 : 0;
    endfunction

    function automatic int m_sum(input logic [3:0][7:0] v);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'(v[i]);
        return s;
    endfunction

    task automatic chk_done(input tally_t r);
        int w;
        w = m_win(r.v);
        chk("done_valid", int'(result_valid), 1);
        chk("done_busy", int'(busy), 0);
        chk("winner", int'(winner), w);
        chk("tie", int'(tie), m_tie(r.v));
        chk("total_votes", int'(total_votes), m_sum(r.v));
        chk("done_sel", int'(cand_sel), w);
        chk("done_leds", int'(leds), int'(r.v[w]));
    endtask

    // Monitor: samples just after each rising edge, checks against the oldest outstanding tally.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (q.size() > 0) begin
                int t;
                t = cyc - q[0].e0;
                if (t < LAT) begin
                    chk("busy", int'(busy), 1);
                    chk("valid_low", int'(result_valid), 0);
                    if (t < 4) begin
                        chk("scan_leds", int'(leds), 0);
                        chk("scan_sel", int'(cand_sel), 0);
                    end else begin
                        int k;
                        k = (t - 4) / H;
                        chk("show_sel", int'(cand_sel), k);
                        chk("show_leds", int'(leds), int'(q[0].v[k]));
                    end
                end else begin
                    chk_done(q[0]);
                    done_rec  = q[0];
                    done_flag = 1;
                    void'(q.pop_front());
                end
            end else if (done_flag) begin
                chk_done(done_rec);
            end else begin
                chk("idle_busy", int'(busy), 0);
                chk("idle_valid", int'(result_valid), 0);
                chk("idle_winner", int'(winner), 0);
                chk("idle_tie", int'(tie), 0);
                chk("idle_total", int'(total_votes), 0);
                chk("idle_sel", int'(cand_sel), 0);
                chk("idle_leds", int'(leds), 0);
            end
        end
    end

    task automatic drive_cycle(input logic cp, input logic [7:0] a, b, c, d);
        @(negedge clk);
        rst = 1'b0;
        close_poll = cp;
        c1 = a; c2 = b; c3 = c; c4 = d;
        // The DUT listens only in IDLE or DONE, i.e. no tally or the last one has finished.
        if (cp && (!active || cyc >= last_e0 + LAT)) begin
            tally_t r;
            r.e0 = cyc + 1;
            r.v  = {d, c, b, a};
            q.push_back(r);
            active  = 1;
            last_e0 = cyc + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, c1, c2, c3, c4);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            close_poll = 1'b0;
            q.delete();
            done_flag = 0;
            active = 0;
        end
    endtask

    task automatic tally(input logic [7:0] a, b, c, d);
        drive_cycle(1'b1, a, b, c, d);
        idle(LAT + 2);
    endtask

    initial begin
        do_reset(3);
        idle(20);

        drive_cycle(1'b1, 8'd5, 8'd9, 8'd3, 8'd7);
        for (int i = 1; i < LAT; i++)
            drive_cycle((i == 2) || (i == 20) || (i == 35), 8'd200, 8'd0, 8'd0, 8'd0);
        idle(3);
        tally(8'd200, 8'd0, 8'd0, 8'd0);

        tally(8'd4, 8'd8, 8'd8, 8'd2);
        tally(8'd0, 8'd0, 8'd0, 8'd0);
        tally(8'd255, 8'd255, 8'd255, 8'd255);
        tally(8'd1, 8'd2, 8'd3, 8'd255);

        for (int i = 0; i < 2 * LAT + 5; i++)
            drive_cycle(1'b1, 8'd10, 8'd30, 8'd30, 8'd30);
        idle(LAT + 2);

        drive_cycle(1'b1, 8'd9, 8'd8, 8'd7, 8'd6);
        idle(4 + 2 * H + 3);
        do_reset(1);
        idle(3);
        tally(8'd1, 8'd1, 8'd2, 8'd0);

        for (int i = 0; i < 2000; i++) begin
            logic [7:0] v [4];
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            for (int j = 0; j < 4; j++)
                v[j] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2));
            else drive_cycle($urandom_range(0, 24) == 0, v[0], v[1], v[2], v[3]);
        end

        for (int i = 0; i < LAT + 10 && q.size() > 0; i++) idle(1);
        chk("drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
